// File: rtl/prbs16_checker_if.sv
// Bus bundle for the PRBS16 checker: received-word handshake, clear strobe
// and the registered lock/error status returned to the receiver.
interface prbs16_checker_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        clear;
  logic        locked;
  logic        err_pulse;
  logic [31:0] word_cnt;
  logic [31:0] err_word_cnt;
  logic [31:0] err_bit_cnt;
  logic        lock_lost;

  modport master (
    output in_valid, in_data, clear,
    input  locked, err_pulse, word_cnt, err_word_cnt, err_bit_cnt, lock_lost
  );

  modport slave (
    input  in_valid, in_data, clear,
    output locked, err_pulse, word_cnt, err_word_cnt, err_bit_cnt, lock_lost
  );
endinterface

// File: rtl/prbs16_checker.sv
// PRBS16 receive checker: seeds from incoming data, verifies LOCK_CNT matches
// before locking, then counts word and bit errors until LOSS_CNT misses in a row.
module prbs16_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic              clk,
  input  logic              rst,
  prbs16_checker_if.slave   bus
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam logic [3:0] LOCK_LIM = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_LIM = 4'(LOSS_CNT);

  function automatic logic [15:0] step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t      state, state_nxt;
  logic [15:0] expected, expected_nxt;
  logic [3:0]  count, count_nxt;
  logic [31:0] words, words_nxt;
  logic [31:0] err_words, err_words_nxt;
  logic [31:0] err_bits, err_bits_nxt;
  logic        pulse, pulse_nxt;
  logic        lost, lost_nxt;
  logic        loss_event;

  logic [15:0] diff;
  logic [4:0]  diff_bits;
  logic [3:0]  count_inc;
  logic [32:0] bits_sum;

  assign diff      = bus.in_data ^ expected;
  assign diff_bits = 5'($countones(diff));
  assign count_inc = count + 4'd1;
  assign bits_sum  = {1'b0, err_bits} + 33'(diff_bits);

  always_comb begin
    state_nxt     = state;
    expected_nxt  = expected;
    count_nxt     = count;
    words_nxt     = words;
    err_words_nxt = err_words;
    err_bits_nxt  = err_bits;
    pulse_nxt     = 1'b0;
    loss_event    = 1'b0;

    if (bus.in_valid) begin
      unique case (state)
        SEARCH: begin
          // All-zero is the LFSR lock-up state and cannot seed a sequence.
          if (bus.in_data != 16'h0000) begin
            expected_nxt = step(bus.in_data);
            count_nxt    = '0;
            state_nxt    = VERIFY;
          end
        end
        VERIFY: begin
          if (diff == 16'h0000) begin
            expected_nxt = step(expected);
            if (count_inc == LOCK_LIM) begin
              state_nxt = LOCKED;
              count_nxt = '0;
            end else begin
              count_nxt = count_inc;
            end
          end else if (bus.in_data != 16'h0000) begin
            expected_nxt = step(bus.in_data);
            count_nxt    = '0;
          end else begin
            state_nxt = SEARCH;
            count_nxt = '0;
          end
        end
        LOCKED: begin
          // Once locked the local generator free-runs; data never reseeds it.
          expected_nxt = step(expected);
          words_nxt    = sat_inc(words);
          if (diff != 16'h0000) begin
            err_words_nxt = sat_inc(err_words);
            err_bits_nxt  = bits_sum[32] ? 32'hFFFF_FFFF : bits_sum[31:0];
            pulse_nxt     = 1'b1;
            if (count_inc == LOSS_LIM) begin
              state_nxt  = SEARCH;
              count_nxt  = '0;
              loss_event = 1'b1;
            end else begin
              count_nxt = count_inc;
            end
          end else begin
            count_nxt = '0;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end

    if (bus.clear) begin
      words_nxt     = '0;
      err_words_nxt = '0;
      err_bits_nxt  = '0;
    end
    // A loss on the same edge as clear must still be reported.
    lost_nxt = loss_event | (lost & ~bus.clear);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      expected  <= '0;
      count     <= '0;
      words     <= '0;
      err_words <= '0;
      err_bits  <= '0;
      pulse     <= 1'b0;
      lost      <= 1'b0;
    end else begin
      state     <= state_nxt;
      expected  <= expected_nxt;
      count     <= count_nxt;
      words     <= words_nxt;
      err_words <= err_words_nxt;
      err_bits  <= err_bits_nxt;
      pulse     <= pulse_nxt;
      lost      <= lost_nxt;
    end
  end

  assign bus.locked       = (state == LOCKED);
  assign bus.err_pulse    = pulse;
  assign bus.word_cnt     = words;
  assign bus.err_word_cnt = err_words;
  assign bus.err_bit_cnt  = err_bits;
  assign bus.lock_lost    = lost;

endmodule
